osd_vram_sched: RTL and testbench
=================================

# osd_vram_sched

Write-port scheduler for the OSD character VRAM feeding the character generator. Shares the single VRAM write port between an external CPU requester (req/ack handshake) and an internal fill engine that clears or paints the whole screen with one character code. Sits between the CPU bus and the character generator's VRAM write inputs. Runs on the 4fsc enable inside the NFSC clock domain.

## Interface
- C_AW, 10, VRAM address width; fill covers 0 .. 2^C_AW-1
- C_DW, 8, VRAM data (character code) width
- CK_i  in  1  system clock (NFSC)
- AR_i  in  1  reset, asynchronous, active-high
- CK_EE_i  in  1  clock enable; all state advances only when 1
- VBLANK_i  in  1  1 = vertical blanking (used only with the gate macro)
- CPU_REQ_i  in  1  CPU write request, level, held until ack
- CPU_WAs_i  in  C_AW  CPU write address, stable while REQ=1
- CPU_WDs_i  in  C_DW  CPU write data, stable while REQ=1
- CPU_ACK_o  out  1  one CK_EE-cycle pulse: CPU write issued
- FILL_REQ_i  in  1  fill start, sampled on CK_EE cycles
- FILL_CHRs_i  in  C_DW  fill character, latched at fill start
- BUSY_o  out  1  1 while fill in progress
- DONE_o  out  1  one CK_EE-cycle pulse after last fill write
- VRAM_WAs_o  out  C_AW  VRAM write address
- VRAM_WDs_o  out  C_DW  VRAM write data
- VRAM_WE_o  out  1  VRAM write enable, valid one CK_EE cycle per write

## Operation
- Reset: all outputs 0, fill counter 0, state IDLE, cooloff flag 0.
- States: IDLE, FILL. IDLE -> FILL when FILL_REQ_i=1 (latch FILL_CHRs_i, counter=0, BUSY_o=1). FILL -> IDLE after the write at address 2^C_AW-1 is issued; DONE_o pulses and BUSY_o drops on that same transition.
- Each CK_EE cycle, at most one write is issued. Grant order: CPU (if REQ=1 and cooloff=0), else fill (if FILL), else none.
- CPU grant: VRAM_WAs/WDs <= CPU inputs, VRAM_WE=1, CPU_ACK=1, cooloff=1. Cooloff masks CPU_REQ_i for exactly the next CK_EE cycle, so a requester that drops REQ on seeing ACK is never written twice. Maximum CPU rate is one write per two CK_EE cycles; fill uses the cooloff slots.
- Fill grant: address = counter, data = latched char, WE=1, counter+1. The counter does not advance on cycles granted to the CPU. A CPU write to an address not yet filled is later overwritten by the fill; this is intended.
- FILL_REQ_i while BUSY_o=1 is ignored; it does not restart the fill.
- FILL_REQ_i and CPU_REQ_i in the same cycle: fill is latched, the CPU is granted first, and the first fill write follows in the next free slot.
- Cycles with no grant: VRAM_WE_o=0, and address/data hold their last values.
- AR_i mid-fill aborts the fill: no DONE pulse, and VRAM contents are partial.

## Timing
- All outputs are registered. Updates happen on CK_i rising edges with CK_EE_i=1; outputs hold while CK_EE_i=0.
- CPU latency: REQ sampled at CK_EE edge n gives WE/ACK high after edge n, for one CK_EE period. The earliest resampling is edge n+2.
- A full fill takes 2^C_AW CK_EE cycles with no CPU traffic (1024 for the default), plus one cycle per CPU write granted during the fill.
- DONE_o is asserted in the same CK_EE cycle as the last fill write's WE_o.

## Configuration
- OSD_VRAM_VBLANK_GATE_EN defined: fill grants are issued only while VBLANK_i=1. The counter pauses outside blanking, and BUSY_o stays 1 across active lines. CPU grants are not gated.
- OSD_VRAM_VBLANK_GATE_EN undefined: VBLANK_i is ignored and fill runs continuously.

## Structure
- Package osd_vram_pkg: state encoding (IDLE, FILL), default C_AW/C_DW constants, and the fill-end address constant.
- Sub-module osd_fill_ctr: fill address counter with enable and clear, and a terminal-count output that drives the FILL -> IDLE transition and DONE_o.

## Test plan
- Reset: hold AR_i=1 with stimulus active, then release -> all outputs 0 and state IDLE.
- Single CPU write: REQ with WA=0x155, WD=0x41 -> one cycle of WE with those values and ACK. With REQ held high 2 more cycles: no WE in the cooloff cycle, then a second write.
- Full fill: FILL_REQ with CHR=0x20 -> WA 0..1023 sequential, WD=0x20. DONE_o pulses with WA=1023 and BUSY_o falls. Total 1024 CK_EE cycles.
- CPU during fill: a CPU write every 2 cycles -> the fill counter skips no address and total fill duration grows by the number of CPU grants. A second FILL_REQ mid-fill is ignored.
- Simultaneous FILL_REQ and CPU_REQ -> CPU write first, fill WA=0 in the next cycle. AR_i pulsed mid-fill -> outputs 0 and no DONE.
- With OSD_VRAM_VBLANK_GATE_EN: VBLANK_i=0 -> no fill WE and counter frozen; VBLANK_i=1 -> fill resumes at the frozen address.

Source files
------------

// File: rtl/osd_vram_pkg.sv
// Shared definitions for the OSD character VRAM write scheduler:
// FSM state encoding, default geometry and the last fill address.
package osd_vram_pkg;

  localparam int unsigned C_AW_DEF = 10;
  localparam int unsigned C_DW_DEF = 8;

  localparam int unsigned FILL_END_ADDR = (1 << C_AW_DEF) - 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

endpackage

// File: rtl/osd_fill_ctr.sv
// Fill address counter with clock enable, synchronous clear and a
// terminal-count flag that marks the last VRAM address of the screen.
module osd_fill_ctr
  import osd_vram_pkg::*;
#(
  parameter int unsigned C_AW = C_AW_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ce_i,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [C_AW-1:0] cnt_o,
  output logic            tc_o
);

  localparam logic [C_AW-1:0] LAST = '1;

  logic [C_AW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt_q <= '0;
    else if (ce_i)
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LAST);

endmodule

// File: rtl/osd_vram_sched.sv
// Arbitrates the single OSD VRAM write port between the CPU and the screen
// fill engine. Define OSD_VRAM_VBLANK_GATE_EN to restrict fill writes to VBLANK.
module osd_vram_sched
  import osd_vram_pkg::*;
#(
  parameter int unsigned C_AW = C_AW_DEF,
  parameter int unsigned C_DW = C_DW_DEF
) (
  input  logic            CK_i,
  input  logic            AR_i,
  input  logic            CK_EE_i,
  input  logic            VBLANK_i,
  input  logic            CPU_REQ_i,
  input  logic [C_AW-1:0] CPU_WAs_i,
  input  logic [C_DW-1:0] CPU_WDs_i,
  output logic            CPU_ACK_o,
  input  logic            FILL_REQ_i,
  input  logic [C_DW-1:0] FILL_CHRs_i,
  output logic            BUSY_o,
  output logic            DONE_o,
  output logic [C_AW-1:0] VRAM_WAs_o,
  output logic [C_DW-1:0] VRAM_WDs_o,
  output logic            VRAM_WE_o
);

  state_t          state_q, state_d;
  logic            cool_q, cool_d;
  logic            ack_q, ack_d;
  logic            done_q, done_d;
  logic            we_q, we_d;
  logic [C_AW-1:0] wa_q, wa_d;
  logic [C_DW-1:0] wd_q, wd_d;
  logic [C_DW-1:0] chr_q, chr_d;

  logic            fill_ok;
  logic            cpu_gnt;
  logic            fill_gnt;
  logic            ctr_clr;
  logic            ctr_en;
  logic [C_AW-1:0] ctr_cnt;
  logic            ctr_tc;

`ifdef OSD_VRAM_VBLANK_GATE_EN
  assign fill_ok = VBLANK_i;
`else
  logic unused_vblank;
  assign unused_vblank = VBLANK_i;
  assign fill_ok       = 1'b1;
`endif

  // Cooloff gives the fill engine every slot right after a CPU write.
  assign cpu_gnt  = CPU_REQ_i && !cool_q;
  assign fill_gnt = !cpu_gnt && (state_q == S_FILL) && fill_ok;

  osd_fill_ctr #(
    .C_AW (C_AW)
  ) u_fill_ctr (
    .clk_i (CK_i),
    .rst_i (AR_i),
    .ce_i  (CK_EE_i),
    .clr_i (ctr_clr),
    .en_i  (ctr_en),
    .cnt_o (ctr_cnt),
    .tc_o  (ctr_tc)
  );

  always_comb begin
    state_d = state_q;
    cool_d  = cpu_gnt;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    chr_d   = chr_q;
    ctr_clr = 1'b0;
    ctr_en  = 1'b0;

    if (cpu_gnt) begin
      wa_d  = CPU_WAs_i;
      wd_d  = CPU_WDs_i;
      we_d  = 1'b1;
      ack_d = 1'b1;
    end else if (fill_gnt) begin
      wa_d   = ctr_cnt;
      wd_d   = chr_q;
      we_d   = 1'b1;
      ctr_en = 1'b1;
      if (ctr_tc) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end

    // Fill start is only accepted when idle, so a repeat request cannot restart it.
    if (state_q == S_IDLE && FILL_REQ_i) begin
      state_d = S_FILL;
      chr_d   = FILL_CHRs_i;
      ctr_clr = 1'b1;
    end
  end

  always_ff @(posedge CK_i or posedge AR_i) begin
    if (AR_i) begin
      state_q <= S_IDLE;
      cool_q  <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      chr_q   <= '0;
    end else if (CK_EE_i) begin
      state_q <= state_d;
      cool_q  <= cool_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      chr_q   <= chr_d;
    end
  end

  assign CPU_ACK_o  = ack_q;
  assign DONE_o     = done_q;
  assign BUSY_o     = (state_q == S_FILL);
  assign VRAM_WE_o  = we_q;
  assign VRAM_WAs_o = wa_q;
  assign VRAM_WDs_o = wd_q;

endmodule

// File: tb/tb_osd_vram_sched.sv
// Directed self-checking bench for osd_vram_sched (default geometry 1024 x 8).
// The gated section runs only when OSD_VRAM_VBLANK_GATE_EN is defined.
module tb_osd_vram_sched;

  logic       CK = 1'b0;
  logic       AR;
  logic       CK_EE;
  logic       VBLANK;
  logic       CPU_REQ;
  logic [9:0] CPU_WA;
  logic [7:0] CPU_WD;
  logic       CPU_ACK;
  logic       FILL_REQ;
  logic [7:0] FILL_CHR;
  logic       BUSY;
  logic       DONE;
  logic [9:0] VRAM_WA;
  logic [7:0] VRAM_WD;
  logic       VRAM_WE;

  int checks = 0;
  int errors = 0;

  always #5 CK = ~CK;

  osd_vram_sched #(
    .C_AW (10),
    .C_DW (8)
  ) dut (
    .CK_i        (CK),
    .AR_i        (AR),
    .CK_EE_i     (CK_EE),
    .VBLANK_i    (VBLANK),
    .CPU_REQ_i   (CPU_REQ),
    .CPU_WAs_i   (CPU_WA),
    .CPU_WDs_i   (CPU_WD),
    .CPU_ACK_o   (CPU_ACK),
    .FILL_REQ_i  (FILL_REQ),
    .FILL_CHRs_i (FILL_CHR),
    .BUSY_o      (BUSY),
    .DONE_o      (DONE),
    .VRAM_WAs_o  (VRAM_WA),
    .VRAM_WDs_o  (VRAM_WD),
    .VRAM_WE_o   (VRAM_WE)
  );

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_we"},   {31'd0, VRAM_WE}, 32'd0);
    chk({tag, "_ack"},  {31'd0, CPU_ACK}, 32'd0);
    chk({tag, "_done"}, {31'd0, DONE},    32'd0);
    chk({tag, "_busy"}, {31'd0, BUSY},    32'd0);
    chk({tag, "_wa"},   {22'd0, VRAM_WA}, 32'd0);
    chk({tag, "_wd"},   {24'd0, VRAM_WD}, 32'd0);
  endtask

  initial begin
    int bad;
    int nfill;
    int acks;
    int cyc;
    int k;
    int we_cnt;
    int done_cnt;
    logic done_seen;

    // Reset held with stimulus active
    AR       = 1'b1;
    CK_EE    = 1'b1;
`ifdef OSD_VRAM_VBLANK_GATE_EN
    VBLANK   = 1'b1;
`else
    VBLANK   = 1'b0;
`endif
    CPU_REQ  = 1'b1;
    CPU_WA   = 10'h3FF;
    CPU_WD   = 8'hFF;
    FILL_REQ = 1'b1;
    FILL_CHR = 8'hAA;
    repeat (3) step();
    chk_idle_outputs("rst_held");
    CPU_REQ  = 1'b0;
    FILL_REQ = 1'b0;
    AR       = 1'b0;
    step();
    chk_idle_outputs("rst_rel");

    // Single CPU write, REQ held through cooloff
    CPU_REQ = 1'b1;
    CPU_WA  = 10'h155;
    CPU_WD  = 8'h41;
    step();
    chk("cpu1_we",  {31'd0, VRAM_WE}, 32'd1);
    chk("cpu1_ack", {31'd0, CPU_ACK}, 32'd1);
    chk("cpu1_wa",  {22'd0, VRAM_WA}, 32'h155);
    chk("cpu1_wd",  {24'd0, VRAM_WD}, 32'h41);
    step();
    chk("cool_we",  {31'd0, VRAM_WE}, 32'd0);
    chk("cool_ack", {31'd0, CPU_ACK}, 32'd0);
    chk("cool_wa",  {22'd0, VRAM_WA}, 32'h155);
    step();
    chk("cpu2_we",  {31'd0, VRAM_WE}, 32'd1);
    chk("cpu2_ack", {31'd0, CPU_ACK}, 32'd1);
    CPU_REQ = 1'b0;
    step();
    chk("cpu2_cool_we", {31'd0, VRAM_WE}, 32'd0);
    step();
    chk("cpu_idle_we", {31'd0, VRAM_WE}, 32'd0);

    // Clock enable low: nothing advances, outputs hold
    CPU_REQ = 1'b1;
    CPU_WA  = 10'h0AA;
    CPU_WD  = 8'h5A;
    CK_EE   = 1'b0;
    step();
    chk("ee0_we", {31'd0, VRAM_WE}, 32'd0);
    CK_EE = 1'b1;
    step();
    chk("ee1_we", {31'd0, VRAM_WE}, 32'd1);
    chk("ee1_wa", {22'd0, VRAM_WA}, 32'h0AA);
    CPU_REQ = 1'b0;
    CK_EE   = 1'b0;
    step();
    chk("ee0_hold_we",  {31'd0, VRAM_WE}, 32'd1);
    chk("ee0_hold_ack", {31'd0, CPU_ACK}, 32'd1);
    CK_EE = 1'b1;
    step();
    chk("ee1_drop_we", {31'd0, VRAM_WE}, 32'd0);
    step();

    // Full fill, no CPU traffic
    FILL_REQ = 1'b1;
    FILL_CHR = 8'h20;
    step();
    FILL_REQ = 1'b0;
    chk("fill_start_busy", {31'd0, BUSY},    32'd1);
    chk("fill_start_we",   {31'd0, VRAM_WE}, 32'd0);
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      step();
      if (VRAM_WE !== 1'b1 || VRAM_WA !== 10'(i) || VRAM_WD !== 8'h20 ||
          DONE !== (i == 1023) || BUSY !== (i != 1023))
        bad++;
    end
    chk("fill_seq_bad", bad, 32'd0);
    chk("fill_end_done", {31'd0, DONE},    32'd1);
    chk("fill_end_busy", {31'd0, BUSY},    32'd0);
    chk("fill_end_wa",   {22'd0, VRAM_WA}, 32'h3FF);
    step();
    chk("fill_post_done", {31'd0, DONE},    32'd0);
    chk("fill_post_we",   {31'd0, VRAM_WE}, 32'd0);

    // Fill with interleaved CPU writes and an ignored re-request
    FILL_REQ = 1'b1;
    FILL_CHR = 8'h2E;
    step();
    FILL_REQ  = 1'b0;
    CPU_REQ   = 1'b1;
    k         = 0;
    CPU_WA    = 10'h200;
    CPU_WD    = 8'hC0;
    nfill     = 0;
    acks      = 0;
    cyc       = 0;
    bad       = 0;
    done_seen = 1'b0;
    while (!done_seen && cyc < 3000) begin
      if (cyc == 100) begin
        FILL_REQ = 1'b1;
        FILL_CHR = 8'h55;
      end else begin
        FILL_REQ = 1'b0;
      end
      step();
      cyc++;
      if (CPU_ACK === 1'b1) begin
        acks++;
        if (VRAM_WE !== 1'b1 || VRAM_WA !== 10'(10'h200 + k) || VRAM_WD !== 8'(8'hC0 + k))
          bad++;
        k++;
        if (k < 20) begin
          CPU_WA = 10'(10'h200 + k);
          CPU_WD = 8'(8'hC0 + k);
        end else begin
          CPU_REQ = 1'b0;
        end
      end else if (VRAM_WE === 1'b1) begin
        if (VRAM_WA !== 10'(nfill) || VRAM_WD !== 8'h2E)
          bad++;
        nfill++;
      end
      if (DONE === 1'b1)
        done_seen = 1'b1;
    end
    FILL_REQ = 1'b0;
    chk("mix_done_seen", {31'd0, done_seen}, 32'd1);
    chk("mix_bad",       bad,   32'd0);
    chk("mix_acks",      acks,  32'd20);
    chk("mix_nfill",     nfill, 32'd1024);
    chk("mix_cycles",    cyc,   32'd1044);
    chk("mix_end_wa",    {22'd0, VRAM_WA}, 32'h3FF);
    chk("mix_end_busy",  {31'd0, BUSY},    32'd0);
    step();

    // Simultaneous fill and CPU request, then reset mid-fill
    FILL_REQ = 1'b1;
    FILL_CHR = 8'h11;
    CPU_REQ  = 1'b1;
    CPU_WA   = 10'h0F0;
    CPU_WD   = 8'h99;
    step();
    FILL_REQ = 1'b0;
    CPU_REQ  = 1'b0;
    chk("sim_ack",  {31'd0, CPU_ACK}, 32'd1);
    chk("sim_wa",   {22'd0, VRAM_WA}, 32'h0F0);
    chk("sim_wd",   {24'd0, VRAM_WD}, 32'h99);
    chk("sim_busy", {31'd0, BUSY},    32'd1);
    step();
    chk("sim_f0_we",  {31'd0, VRAM_WE}, 32'd1);
    chk("sim_f0_ack", {31'd0, CPU_ACK}, 32'd0);
    chk("sim_f0_wa",  {22'd0, VRAM_WA}, 32'h000);
    chk("sim_f0_wd",  {24'd0, VRAM_WD}, 32'h11);
    step();
    chk("sim_f1_wa", {22'd0, VRAM_WA}, 32'h001);
    step();
    step();
    chk("sim_f3_wa", {22'd0, VRAM_WA}, 32'h003);
    #2;
    AR = 1'b1;
    #1;
    chk_idle_outputs("abort_async");
    step();
    AR = 1'b0;
    we_cnt   = 0;
    done_cnt = 0;
    for (int i = 0; i < 1100; i++) begin
      step();
      if (VRAM_WE === 1'b1) we_cnt++;
      if (DONE === 1'b1)    done_cnt++;
    end
    chk("abort_we_cnt",   we_cnt,   32'd0);
    chk("abort_done_cnt", done_cnt, 32'd0);
    chk("abort_busy",     {31'd0, BUSY}, 32'd0);

`ifdef OSD_VRAM_VBLANK_GATE_EN
    // Fill gated by vertical blanking
    VBLANK   = 1'b0;
    FILL_REQ = 1'b1;
    FILL_CHR = 8'h7E;
    step();
    FILL_REQ = 1'b0;
    we_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (VRAM_WE === 1'b1) we_cnt++;
    end
    chk("gate_off_we_cnt", we_cnt, 32'd0);
    chk("gate_off_busy",   {31'd0, BUSY}, 32'd1);
    VBLANK = 1'b1;
    repeat (5) step();
    chk("gate_on_wa", {22'd0, VRAM_WA}, 32'h004);
    chk("gate_on_wd", {24'd0, VRAM_WD}, 32'h7E);
    VBLANK = 1'b0;
    step();
    chk("gate_pause_we", {31'd0, VRAM_WE}, 32'd0);
    repeat (4) step();
    VBLANK = 1'b1;
    step();
    chk("gate_resume_we", {31'd0, VRAM_WE}, 32'd1);
    chk("gate_resume_wa", {22'd0, VRAM_WA}, 32'h005);
    AR = 1'b1;
    step();
    AR = 1'b0;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
